inst_queue: RTL and testbench



---
 rtl/inst_queue_pkg.sv | 19 +
 rtl/inst_queue_if.sv | 34 +++
 rtl/inst_queue.sv | 127 ++++++++++++
 tb/tb_inst_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the instruction queue between fetch and decode.
// The fetch stage imports IQ_DEPTH to size its outstanding requests.
package inst_queue_pkg;

  localparam int IQ_DEPTH  = 4;
  localparam int IQ_INST_W = 32;
  localparam int IQ_PC_W   = 32;

  // Word presented to decode when the queue is empty.
  localparam logic [31:0] INST_NOP = 32'h0;

  // How this cycle's flush request resolves once the same-cycle pop is accounted for.
  typedef enum logic [1:0] {
    FLUSH_NONE,
    FLUSH_ALL,
    FLUSH_KEEP
  } flush_mode_e;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push channel and decode-side pop channel of the instruction queue.
// master = the pipeline around the queue (fetch + decode), slave = the queue.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int INST_W = IQ_INST_W,
  parameter int PC_W   = IQ_PC_W
) ();

  logic              push_valid;
  logic              push_ready;
  logic [INST_W-1:0] push_inst;
  logic [PC_W-1:0]   push_pc;
  logic              push_pred_taken;
  logic              push_adel;

  logic              pop_valid;
  logic              pop_ready;
  logic [INST_W-1:0] pop_inst;
  logic [PC_W-1:0]   pop_pc;
  logic              pop_pred_taken;
  logic              pop_adel;

  modport master (
    output push_valid, push_inst, push_pc, push_pred_taken, push_adel, pop_ready,
    input  push_ready, pop_valid, pop_inst, pop_pc, pop_pred_taken, pop_adel
  );

  modport slave (
    input  push_valid, push_inst, push_pc, push_pred_taken, push_adel, pop_ready,
    output push_ready, pop_valid, pop_inst, pop_pc, pop_pred_taken, pop_adel
  );

endinterface

// File: rtl/inst_queue.sv
// Instruction queue: DEPTH-entry circular buffer of fetched words with PC,
// predicted-taken and AdEL flag. The oldest entry is shown to decode with no
// bypass; flush can optionally retain the post-pop head as the delay slot.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int INST_W = IQ_INST_W,
  parameter int PC_W   = IQ_PC_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   flush_keep_head,
  inst_queue_if.slave            bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              pred_taken;
    logic              adel;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full, empty;
  logic             push_fire, pop_fire;
  logic [PTR_W-1:0] head_ptr;
  logic [CNT_W-1:0] kept_cnt;
  flush_mode_e      flush_mode;

  // push_ready looks only at the registered count, so a same-cycle pop never
  // opens room for a push on a full queue.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign bus.push_ready = !full;
  assign bus.pop_valid  = !empty;

  assign push_fire = bus.push_valid & !full & !flush;
  assign pop_fire  = !empty & bus.pop_ready;

  // Head and occupancy as they stand after this cycle's pop.
  assign head_ptr = rd_ptr_q + PTR_W'(pop_fire);
  assign kept_cnt = count_q - CNT_W'(pop_fire);

  // Resolve the flush request: keeping the head only makes sense if one survives the pop.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    flush_mode = FLUSH_NONE;
    if (flush) begin
      if (flush_keep_head && (kept_cnt != '0)) flush_mode = FLUSH_KEEP;
      else                                     flush_mode = FLUSH_ALL;
    end
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = head_ptr;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_fire);
    count_d  = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    unique case (flush_mode)
      FLUSH_ALL: begin
        // Push is already suppressed under flush, so wr_ptr_q is the new tail.
        rd_ptr_d = wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = '0;
      end
      FLUSH_KEEP: begin
        rd_ptr_d = head_ptr;
        wr_ptr_d = head_ptr + PTR_W'(1);
        count_d  = CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written on push fire.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; stale contents are never visible because outputs are gated by count.
    if (push_fire) begin
      mem_q[wr_ptr_q] <= '{inst:       bus.push_inst,
                           pc:         bus.push_pc,
                           pred_taken: bus.push_pred_taken,
                           adel:       bus.push_adel};
    end
  end

  // Head read-out, forced to NOP/zero whenever the queue is empty.
  always_comb begin
    bus.pop_inst       = INST_W'(INST_NOP);
    bus.pop_pc         = '0;
    bus.pop_pred_taken = 1'b0;
    bus.pop_adel       = 1'b0;
    if (!empty) begin
      bus.pop_inst       = mem_q[rd_ptr_q].inst;
      bus.pop_pc         = mem_q[rd_ptr_q].pc;
      bus.pop_pred_taken = mem_q[rd_ptr_q].pred_taken;
      bus.pop_adel       = mem_q[rd_ptr_q].adel;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a queue-based model.
module tb_inst_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pt;
    logic        adel;
  } entry_t;

  logic       clk;
  logic       resetn;
  logic       flush;
  logic       flush_keep_head;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  inst_queue_if #(.INST_W(32), .PC_W(32)) iq ();

  inst_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .flush_keep_head (flush_keep_head),
    .bus             (iq),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  entry_t model_q[$];
  bit     m_push, m_pop;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_q.delete();
    end else begin
      m_push = iq.push_valid && (model_q.size() < DEPTH) && !flush;
      m_pop  = iq.pop_ready && (model_q.size() > 0);
      if (m_pop) void'(model_q.pop_front());
      if (flush) begin
        if (flush_keep_head && model_q.size() > 0) begin
          while (model_q.size() > 1) void'(model_q.pop_back());
        end else begin
          model_q.delete();
        end
      end else if (m_push) begin
        model_q.push_back('{iq.push_inst, iq.push_pc, iq.push_pred_taken, iq.push_adel});
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  entry_t exp_head;
  always @(negedge clk) begin
    if (model_q.size() > 0) exp_head = model_q[0];
    else                    exp_head = '{32'h0, 32'h0, 1'b0, 1'b0};
    check("cmp_count",      64'(count),             64'(model_q.size()));
    check("cmp_push_ready", 64'(iq.push_ready),     64'(model_q.size() < DEPTH));
    check("cmp_pop_valid",  64'(iq.pop_valid),      64'(model_q.size() > 0));
    check("cmp_pop_inst",   64'(iq.pop_inst),       64'(exp_head.inst));
    check("cmp_pop_pc",     64'(iq.pop_pc),         64'(exp_head.pc));
    check("cmp_pop_pt",     64'(iq.pop_pred_taken), 64'(exp_head.pt));
    check("cmp_pop_adel",   64'(iq.pop_adel),       64'(exp_head.adel));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic pv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pt, input logic adel, input logic pr,
                       input logic fl, input logic kp);
    iq.push_valid      = pv;
    iq.push_inst       = inst;
    iq.push_pc         = pc;
    iq.push_pred_taken = pt;
    iq.push_adel       = adel;
    iq.pop_ready       = pr;
    flush              = fl;
    flush_keep_head    = kp;
  endtask

  task automatic idle(input logic pr);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, pr, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(1'b0);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  logic [31:0] exp_pcs [4];

  initial begin
    resetn = 1'b1;
    idle(1'b0);
    do_reset();

    // 1: reset state, then single push visible the following cycle only.
    check("rst_count",      64'(count),         64'd0);
    check("rst_push_ready", 64'(iq.push_ready), 64'd1);
    check("rst_pop_valid",  64'(iq.pop_valid),  64'd0);
    check("rst_pop_inst",   64'(iq.pop_inst),   64'd0);
    drive(1'b1, 32'h24020005, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("t1_no_bypass", 64'(iq.pop_valid), 64'd0);
    step();
    idle(1'b0);
    check("t1_pop_valid", 64'(iq.pop_valid), 64'd1);
    check("t1_pop_inst",  64'(iq.pop_inst),  64'h24020005);
    check("t1_pop_pc",    64'(iq.pop_pc),    64'hBFC00000);
    check("t1_count",     64'(count),        64'd1);

    // 2: fill past capacity, then drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("t2_full_ready", 64'(iq.push_ready), 64'd0);
    check("t2_full_count", 64'(count),         64'd4);
    drive(1'b1, 32'h1004, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("t2_held_count", 64'(count), 64'd4);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_pc",   64'(iq.pop_pc),   64'(i * 4));
      check("t2_drain_inst", 64'(iq.pop_inst), 64'(32'h1000 + 32'(i)));
      step();
    end
    idle(1'b0);
    check("t2_empty_valid", 64'(iq.pop_valid), 64'd0);
    check("t2_empty_inst",  64'(iq.pop_inst),  64'd0);
    check("t2_empty_pc",    64'(iq.pop_pc),    64'd0);

    // 3: full queue with push and pop together: only the pop fires.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2000 + 32'(i), 32'h40 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h2080, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("t3_ready_full", 64'(iq.push_ready), 64'd0);
    step();
    check("t3_count_after_pop", 64'(count),       64'd3);
    check("t3_head",            64'(iq.pop_pc),   64'h44);
    drive(1'b1, 32'h2080, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("t3_push_fired", 64'(count), 64'd4);
    exp_pcs = '{32'h44, 32'h48, 32'h4C, 32'h80};
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 64'(iq.pop_pc), 64'(exp_pcs[i]));
      step();
    end

    // 4: flush keeping the delay slot while the head is consumed.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h3999, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 check("t4_head_before", 64'(iq.pop_pc), 64'h100);
    step();
    idle(1'b0);
    check("t4_count", 64'(count),     64'd1);
    check("t4_slot",  64'(iq.pop_pc), 64'h104);
    idle(1'b1);
    step();
    idle(1'b0);
    check("t4_drained", 64'(count),        64'd0);
    check("t4_valid",   64'(iq.pop_valid), 64'd0);

    // 5: keep-flush with nothing left after the pop; plain flush of three.
    drive(1'b1, 32'h4000, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check("t5_keep_empty_count", 64'(count),        64'd0);
    check("t5_keep_empty_valid", 64'(iq.pop_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + 32'(i), 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("t5_pre_flush", 64'(count), 64'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle(1'b0);
    check("t5_plain_flush", 64'(count), 64'd0);

    // 6: asynchronous reset mid-stream, then AdEL propagation.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h6000 + 32'(i), 32'h600 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(1'b0);
    check("t6_pre_count", 64'(count), 64'd2);
    #1 resetn = 1'b0;
    #1;
    check("t6_async_valid", 64'(iq.pop_valid), 64'd0);
    check("t6_async_count", 64'(count),        64'd0);
    check("t6_async_pc",    64'(iq.pop_pc),    64'd0);
    #10 resetn = 1'b1;
    step();
    drive(1'b1, 32'h00000055, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    check("t6_adel", 64'(iq.pop_adel),       64'd1);
    check("t6_pt",   64'(iq.pop_pred_taken), 64'd1);
    check("t6_pc",   64'(iq.pop_pc),         64'h400);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 9) < 7), $urandom(), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)));
      step();
    end
    idle(1'b0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
